// File: rtl/draw_mux_pkg.sv
// Shared constants and helpers for the layered draw multiplexer.
// Holds the default colour keys and the channel-index width function.
package draw_mux_pkg;

    localparam logic [7:0] DRAW_DEFAULT_RGB     = 8'hFF;
    localparam logic [7:0] DRAW_TRANSPARENT_RGB = 8'h00;

    // Index width for n channels; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/lowest_index_encoder.sv
// Combinational priority encoder: reports whether any bit is set and the
// index of the lowest set bit (lowest index = highest priority).
module lowest_index_encoder #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan upward; the first set bit latches the index and blocks later ones.
    always_comb begin
        valid = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            idx   = (vec[i] && !valid) ? IDX_W'(i) : idx;
            valid = valid | vec[i];
        end
    end

endmodule

// File: rtl/layered_draw_mux.sv
// Layered pixel multiplexer: lowest-index visible, non-transparent channel
// wins each pixel; collisions with the player channel are gathered per frame.
module layered_draw_mux
    import draw_mux_pkg::*;
#(
    parameter int               CHANNELS        = 16,
    parameter int               RGB_W           = 8,
    parameter logic [RGB_W-1:0] DEFAULT_RGB     = RGB_W'(DRAW_DEFAULT_RGB),
    parameter logic [RGB_W-1:0] TRANSPARENT_RGB = RGB_W'(DRAW_TRANSPARENT_RGB),
    parameter int               PLAYER_IDX      = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           startOfFrame,
    input  logic [CHANNELS-1:0]            inputInsideRectangle,
    input  logic [CHANNELS-1:0][RGB_W-1:0] RGBvector,
    input  logic                           mask_wr,
    input  logic [CHANNELS-1:0]            mask_data,
    output logic                           drawingRequest,
    output logic [RGB_W-1:0]               RGBout,
    output logic [idx_w(CHANNELS)-1:0]     winner,
    output logic [CHANNELS-1:0]            collision_vec,
    output logic                           collision_valid
);

    localparam int IDX_W = idx_w(CHANNELS);

    logic [CHANNELS-1:0] mask_r;
    logic [CHANNELS-1:0] acc_r;
    logic [CHANNELS-1:0] eff_s;
    logic [CHANNELS-1:0] hit_s;
    logic                enc_valid_s;
    logic [IDX_W-1:0]    enc_idx_s;

    // Effective request: inside, enabled, and not the transparent colour key.
    always_comb begin
        eff_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            eff_s[i] = inputInsideRectangle[i] & mask_r[i]
                       & (RGBvector[i] != TRANSPARENT_RGB);
        end
    end

    // A channel hits when it and the player both draw; the player never hits itself.
    always_comb begin
        hit_s             = eff_s & {CHANNELS{eff_s[PLAYER_IDX]}};
        hit_s[PLAYER_IDX] = 1'b0;
    end

    lowest_index_encoder #(
        .N     (CHANNELS),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec   (eff_s),
        .valid (enc_valid_s),
        .idx   (enc_idx_s)
    );

    // Pixel output, mask and collision registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            drawingRequest  <= 1'b0;
            RGBout          <= DEFAULT_RGB;
            winner          <= {IDX_W{1'b0}};
            mask_r          <= {CHANNELS{1'b1}};
            acc_r           <= {CHANNELS{1'b0}};
            collision_vec   <= {CHANNELS{1'b0}};
            collision_valid <= 1'b0;
        end else begin
            drawingRequest <= enc_valid_s;
            RGBout         <= enc_valid_s ? RGBvector[enc_idx_s] : DEFAULT_RGB;
            winner         <= enc_valid_s ? enc_idx_s : {IDX_W{1'b0}};
            if (mask_wr) begin
                mask_r <= mask_data;
            end else begin
                mask_r <= mask_r;
            end
            // The startOfFrame pixel already belongs to the new frame.
            if (startOfFrame) begin
                collision_vec   <= acc_r;
                acc_r           <= hit_s;
                collision_valid <= 1'b1;
            end else begin
                collision_vec   <= collision_vec;
                acc_r           <= acc_r | hit_s;
                collision_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layered_draw_mux.sv
// Self-checking bench for layered_draw_mux: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_layered_draw_mux;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sof = 1'b0;
    logic             mask_wr = 1'b0;
    logic [15:0]      ins = 16'h0000;
    logic [15:0]      mask_data = 16'h0000;
    logic [15:0][7:0] rgbv;

    logic             dr;
    logic [7:0]       rgb;
    logic [3:0]       win;
    logic [15:0]      cv;
    logic             cvalid;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model state and expectations
    logic [15:0] m_mask, m_acc, exp_cv;
    logic        exp_dr, exp_valid;
    logic [7:0]  exp_rgb;
    logic [3:0]  exp_win;

    layered_draw_mux dut (
        .clk                  (clk),
        .reset                (reset),
        .startOfFrame         (sof),
        .inputInsideRectangle (ins),
        .RGBvector            (rgbv),
        .mask_wr              (mask_wr),
        .mask_data            (mask_data),
        .drawingRequest       (dr),
        .RGBout               (rgb),
        .winner               (win),
        .collision_vec        (cv),
        .collision_valid      (cvalid)
    );

    always #5 clk = ~clk;

    // Reference: pick the first drawing channel, collect player overlaps per frame.
    always @(posedge clk) begin : model
        int w;
        logic [15:0] eff, h;
        if (reset) begin
            exp_dr = 1'b0; exp_rgb = 8'hFF; exp_win = 4'd0;
            m_mask = 16'hFFFF; m_acc = 16'h0000;
            exp_cv = 16'h0000; exp_valid = 1'b0;
        end else begin
            for (int i = 0; i < 16; i++)
                eff[i] = ins[i] && m_mask[i] && (rgbv[i] != 8'h00);
            w = -1;
            for (int i = 0; i < 16; i++)
                if (eff[i] && w < 0) w = i;
            exp_dr  = (w >= 0);
            exp_rgb = (w >= 0) ? rgbv[w] : 8'hFF;
            exp_win = (w >= 0) ? 4'(w) : 4'd0;
            for (int i = 0; i < 16; i++)
                h[i] = (i != 0) && eff[i] && eff[0];
            if (sof) begin
                exp_cv = m_acc; m_acc = h; exp_valid = 1'b1;
            end else begin
                m_acc = m_acc | h; exp_valid = 1'b0;
            end
            if (mask_wr) m_mask = mask_data;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                n_cmp += 5;
                if (dr !== exp_dr) begin
                    n_bad++; $display("FAIL cmp drawingRequest got %0h exp %0h t=%0t", dr, exp_dr, $time);
                end
                if (rgb !== exp_rgb) begin
                    n_bad++; $display("FAIL cmp RGBout got %0h exp %0h t=%0t", rgb, exp_rgb, $time);
                end
                if (win !== exp_win) begin
                    n_bad++; $display("FAIL cmp winner got %0d exp %0d t=%0t", win, exp_win, $time);
                end
                if (cv !== exp_cv) begin
                    n_bad++; $display("FAIL cmp collision_vec got %0h exp %0h t=%0t", cv, exp_cv, $time);
                end
                if (cvalid !== exp_valid) begin
                    n_bad++; $display("FAIL cmp collision_valid got %0h exp %0h t=%0t", cvalid, exp_valid, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h exp %0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [15:0] i, input logic s,
                         input logic w, input logic [15:0] d);
        @(negedge clk);
        reset = r; ins = i; sof = s; mask_wr = w; mask_data = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rgbv[i] = 8'hAA;
        rgbv[0] = 8'h11; rgbv[3] = 8'h1C; rgbv[5] = 8'h55; rgbv[7] = 8'hE0; rgbv[9] = 8'h99;

        apply(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk_en = 1'b1;
        apply(1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h0000);
        chk("rst_dr", 32'(dr), 32'h0);
        chk("rst_rgb", 32'(rgb), 32'hFF);
        chk("rst_win", 32'(win), 32'h0);
        chk("rst_cv", 32'(cv), 32'h0);
        chk("rst_cvalid", 32'(cvalid), 32'h0);

        // priority between channels 3 and 7
        apply(1'b0, 16'h0088, 1'b0, 1'b0, 16'h0000);
        chk("prio_rgb", 32'(rgb), 32'h1C);
        chk("prio_win", 32'(win), 32'd3);
        chk("prio_dr", 32'(dr), 32'h1);
        rgbv[3] = 8'h00;
        apply(1'b0, 16'h0088, 1'b0, 1'b0, 16'h0000);
        chk("transp_rgb", 32'(rgb), 32'hE0);
        chk("transp_win", 32'(win), 32'd7);
        apply(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("idle_rgb", 32'(rgb), 32'hFF);
        chk("idle_dr", 32'(dr), 32'h0);
        rgbv[3] = 8'h1C;

        // mask write takes effect one cycle later
        apply(1'b0, 16'h0088, 1'b0, 1'b1, 16'hFFF7);
        chk("maskwr_win", 32'(win), 32'd3);
        apply(1'b0, 16'h0088, 1'b0, 1'b0, 16'h0000);
        chk("masked_win", 32'(win), 32'd7);
        chk("masked_rgb", 32'(rgb), 32'hE0);
        apply(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF);

        // player/channel 5 overlap mid-frame
        apply(1'b0, 16'h0021, 1'b0, 1'b0, 16'h0000);
        apply(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        apply(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("f1_valid", 32'(cvalid), 32'h1);
        chk("f1_cv", 32'(cv), 32'h0020);
        apply(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("f1_pulse", 32'(cvalid), 32'h0);
        chk("f1_hold", 32'(cv), 32'h0020);
        apply(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("f2_cv", 32'(cv), 32'h0000);

        // overlap on the startOfFrame pixel itself belongs to the new frame
        apply(1'b0, 16'h0021, 1'b1, 1'b0, 16'h0000);
        chk("sofhit_cv", 32'(cv), 32'h0000);
        chk("sofhit_valid", 32'(cvalid), 32'h1);
        apply(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        apply(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("sofhit_next", 32'(cv), 32'h0020);

        // back-to-back frame starts
        apply(1'b0, 16'h0201, 1'b1, 1'b0, 16'h0000);
        chk("b2b_first", 32'(cv), 32'h0000);
        apply(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("b2b_second", 32'(cv), 32'h0200);
        chk("b2b_valid", 32'(cvalid), 32'h1);
        apply(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("b2b_third", 32'(cv), 32'h0000);

        // reset mid-frame discards hits and restores the mask
        apply(1'b0, 16'h0021, 1'b0, 1'b0, 16'h0000);
        apply(1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFF7);
        apply(1'b1, 16'h0029, 1'b1, 1'b1, 16'h0000);
        chk("midrst_dr", 32'(dr), 32'h0);
        chk("midrst_rgb", 32'(rgb), 32'hFF);
        chk("midrst_cvalid", 32'(cvalid), 32'h0);
        apply(1'b0, 16'h0008, 1'b0, 1'b0, 16'h0000);
        chk("midrst_mask", 32'(win), 32'd3);
        apply(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("midrst_cv", 32'(cv), 32'h0000);
        chk("midrst_valid", 32'(cvalid), 32'h1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic r, s, w;
            logic [15:0] i, d;
            for (int c = 0; c < 16; c++)
                rgbv[c] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            i = 16'($urandom) & 16'($urandom);
            i[0] = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 24) == 0) || (sof && $urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 49) == 0);
            d = 16'($urandom) | 16'($urandom);
            apply(r, i, s, w, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
